regfile_rename_mp: RTL and testbench
====================================

Name: regfile_rename_mp

Overview:
- Parametrised architectural register file with per-register rename tag (ROB id), for the Tomasulo-style out-of-order core.
- Sits between dispatcher (rename/operand fetch) and ROB (commit/rollback).
- Generalises the single-issue register file: configurable width, register count, tag width and number of read ports; honours rdy_in; keeps a registered count of pending (renamed) registers for stall/debug logic.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers (power of two, >=2)
TAG_W, 5, rename tag width; tag 0 = "no producer, value valid"
NRP, 2, number of operand read ports
RIDX_W, $clog2(NREG), register index width (derived)
CNT_W, $clog2(NREG)+1, pending counter width (derived)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; low = freeze all state updates
dispatch_en  input  1  rename rd to dispatch_tag this cycle
dispatch_rd  input  RIDX_W  destination register being renamed
dispatch_tag  input  TAG_W  new producer tag (ROB id)
rs_idx  input  NRP*RIDX_W  read indices, port k at [k*RIDX_W +: RIDX_W]
rs_val  output  NRP*XLEN  read values, port k at [k*XLEN +: XLEN]
rs_tag  output  NRP*TAG_W  read tags (0 = value valid), port k at [k*TAG_W +: TAG_W]
commit_en  input  1  ROB commits a result
commit_rd  input  RIDX_W  committed destination
commit_tag  input  TAG_W  tag of committing entry
commit_val  input  XLEN  committed value
rollback  input  1  ROB flush: discard all rename tags
pending_cnt  output  CNT_W  registered count of registers with nonzero tag
all_ready  output  1  pending_cnt == 0

Behaviour:
- Storage: V[NREG] (XLEN), Q[NREG] (TAG_W). Reset (rst_in high at clk edge, regardless of rdy_in): all V=0, all Q=0, pending_cnt=0, all_ready=1.
- Register 0 hardwired: never written; reads always V=0, Q=0; dispatch/commit to rd 0 ignored.
- Effective controls (combinational): act = rdy_in & !rst_in; dsp = act & dispatch_en & !rollback & dispatch_rd!=0; cmt = act & commit_en & commit_rd!=0.
- Commit clears tag (clr) iff cmt and commit_tag equals the tag rd will hold otherwise: dispatch_tag if dsp & dispatch_rd==commit_rd, else Q[commit_rd]. With rollback, tag is cleared anyway.
- Read ports (combinational, zero latency, same-cycle bypass), for each port k, r = rs_idx[k]:
  - rs_val: r==0 -> 0; cmt & commit_rd==r -> commit_val; else V[r].
  - rs_tag: r==0 -> 0; clr & commit_rd==r -> 0; dsp & dispatch_rd==r -> dispatch_tag; rollback & act -> 0; else Q[r].
  - All ports independent; same index on several ports returns identical results.
- Clock edge (act only; rdy_in low holds every register and counter):
  - rollback: all Q <= 0 (dispatch ignored this cycle).
  - else dsp: Q[dispatch_rd] <= dispatch_tag.
  - cmt: V[commit_rd] <= commit_val; if clr, Q[commit_rd] <= 0 (overrides dispatch to same rd).
- pending_cnt: next value = number of nonzero Q after the edge's updates; maintained incrementally (+1 when a zero tag becomes nonzero, -1 when nonzero becomes zero; dispatch retagging an already-pending register: no change; simultaneous +1 and -1 on different registers: no change; rollback: 0). all_ready registered alongside. Never exceeds NREG-1.
- dispatch_tag==0 with dispatch_en is illegal (verification asserts it never occurs).
- Reset mid-operation: any in-flight dispatch/commit in the reset cycle is discarded.

Test Plan:
- Reset, then read x5 and x0 on both ports -> rs_val=0, rs_tag=0, pending_cnt=0, all_ready=1.
- Dispatch rd=3 tag=7; same cycle read x3 -> rs_tag=7 (bypass); next cycle rs_tag=7, pending_cnt=1, all_ready=0.
- Commit rd=3 tag=7 val=0xDEADBEEF while port1 reads x3 -> same cycle rs_val=0xDEADBEEF, rs_tag=0; next cycle Q[3]=0, pending_cnt=0.
- Rename x4 tag=2, then x4 tag=9; commit x4 tag=2 val=0x11 -> V[4]=0x11, rs_tag stays 9, pending_cnt=1.
- Same cycle: dispatch x6 tag=4 and commit x6 tag=4 val=0x55 -> Q[6]=0, V[6]=0x55; with tag=5 on dispatch instead -> Q[6]=5.
- Rename x1,x2,x3 (pending_cnt=3), then rollback with simultaneous dispatch x8 tag=3 and rdy_in low for one cycle before it -> count holds 3 while rdy_in low; after rollback all tags 0, x8 not renamed, pending_cnt=0.

Source files
------------

// File: rtl/regfile_rename_mp.sv
// Architectural register file with per-register rename tags (ROB ids).
// Multi-port reads with same-cycle dispatch/commit bypass and a pending counter.
module regfile_rename_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int TAG_W  = 5,
  parameter int NRP    = 2,
  parameter int RIDX_W = $clog2(NREG),
  parameter int CNT_W  = $clog2(NREG) + 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  dispatch_en,
  input  logic [RIDX_W-1:0]     dispatch_rd,
  input  logic [TAG_W-1:0]      dispatch_tag,
  input  logic [NRP*RIDX_W-1:0] rs_idx,
  output logic [NRP*XLEN-1:0]   rs_val,
  output logic [NRP*TAG_W-1:0]  rs_tag,
  input  logic                  commit_en,
  input  logic [RIDX_W-1:0]     commit_rd,
  input  logic [TAG_W-1:0]      commit_tag,
  input  logic [XLEN-1:0]       commit_val,
  input  logic                  rollback,
  output logic [CNT_W-1:0]      pending_cnt,
  output logic                  all_ready
);

  logic [XLEN-1:0]  v_q [NREG];
  logic [XLEN-1:0]  v_d [NREG];
  logic [TAG_W-1:0] q_q [NREG];
  logic [TAG_W-1:0] q_d [NREG];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_all_q, rdy_all_d;

  logic             act, dsp, cmt, clr;
  logic             same_rd;
  logic [TAG_W-1:0] cmt_cur_tag;

  // Effective controls; clr compares against the tag rd would hold after dispatch.
  always_comb begin
    act         = rdy_in & ~rst_in;
    dsp         = act & dispatch_en & ~rollback &
                  (dispatch_rd != '0);
    cmt         = act & commit_en & (commit_rd != '0);
    same_rd     = dsp & (dispatch_rd == commit_rd);
    cmt_cur_tag = same_rd ? dispatch_tag : q_q[commit_rd];
    clr         = cmt & (commit_tag == cmt_cur_tag);
  end

  // Zero-latency read ports with bypass of this cycle's commit and dispatch.
  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [RIDX_W-1:0] r;
    assign r = rs_idx[k*RIDX_W +: RIDX_W];
    assign rs_val[k*XLEN +: XLEN] =
      (r == '0)                 ? '0 :
      (cmt && commit_rd == r)   ? commit_val :
      v_q[r];
    assign rs_tag[k*TAG_W +: TAG_W] =
      (r == '0)                 ? '0 :
      (clr && commit_rd == r)   ? '0 :
      (dsp && dispatch_rd == r) ? dispatch_tag :
      (rollback && act)         ? '0 :
      q_q[r];
  end

  // Next-state storage: rollback wipes tags, commit clear beats dispatch.
  always_comb begin
    v_d = v_q;
    q_d = q_q;
    if (act && rollback) begin
      q_d = '{default: '0};
    end else if (dsp) begin
      q_d[dispatch_rd] = dispatch_tag;
    end
    if (cmt) begin
      v_d[commit_rd] = commit_val;
      if (clr) begin
        q_d[commit_rd] = '0;
      end
    end
  end

  logic d_old, d_new, c_sep, c_old, c_new;
  logic up, dn;

  // Incremental pending count from the (at most two) registers touched.
  always_comb begin
    d_old = (q_q[dispatch_rd] != '0);
    d_new = (dispatch_tag != '0) &
            ~(clr & (commit_rd == dispatch_rd));
    c_sep = cmt & ~same_rd;
    c_old = (q_q[commit_rd] != '0);
    c_new = c_old & ~clr;
    up    = dsp & ~d_old & d_new;
    dn    = (dsp & d_old & ~d_new) |
            (c_sep & c_old & ~c_new);
    if (!act) begin
      cnt_d = cnt_q;
    end else if (rollback) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(up) - CNT_W'(dn);
    end
    rdy_all_d = (cnt_d == '0);
  end

  // State registers: synchronous reset, frozen while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v_q       <= '{default: '0};
      q_q       <= '{default: '0};
      cnt_q     <= '0;
      rdy_all_q <= 1'b1;
    end else if (rdy_in) begin
      v_q       <= v_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      rdy_all_q <= rdy_all_d;
    end
  end

  assign pending_cnt = cnt_q;
  assign all_ready   = rdy_all_q;

endmodule

// File: tb/tb_regfile_rename_mp.sv
// Self-checking bench for regfile_rename_mp.
// Directed scenarios plus a per-cycle comparison against an array model.
module tb_regfile_rename_mp;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        dispatch_en;
  logic [4:0]  dispatch_rd, dispatch_tag;
  logic [9:0]  rs_idx;
  logic [63:0] rs_val;
  logic [9:0]  rs_tag;
  logic        commit_en;
  logic [4:0]  commit_rd, commit_tag;
  logic [31:0] commit_val;
  logic        rollback;
  logic [5:0]  pending_cnt;
  logic        all_ready;

  regfile_rename_mp dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dispatch_en(dispatch_en), .dispatch_rd(dispatch_rd),
    .dispatch_tag(dispatch_tag), .rs_idx(rs_idx),
    .rs_val(rs_val), .rs_tag(rs_tag),
    .commit_en(commit_en), .commit_rd(commit_rd),
    .commit_tag(commit_tag), .commit_val(commit_val),
    .rollback(rollback), .pending_cnt(pending_cnt),
    .all_ready(all_ready)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  logic [31:0] mV [32];
  logic [4:0]  mQ [32];
  int          mcnt = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic void ctl(output bit a, output bit d,
                              output bit c, output bit cl);
    logic [4:0] cur;
    a   = rdy_in && !rst_in;
    d   = a && dispatch_en && !rollback && dispatch_rd != 0;
    c   = a && commit_en && commit_rd != 0;
    cur = (d && dispatch_rd == commit_rd) ? dispatch_tag
                                          : mQ[commit_rd];
    cl  = c && commit_tag == cur;
  endfunction

  // Model state update at each clock edge.
  always @(posedge clk_in) begin
    bit a, d, c, cl;
    ctl(a, d, c, cl);
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        mV[i] = 0;
        mQ[i] = 0;
      end
    end else if (a) begin
      if (rollback)
        for (int i = 0; i < 32; i++) mQ[i] = 0;
      else if (d)
        mQ[dispatch_rd] = dispatch_tag;
      if (c) begin
        mV[commit_rd] = commit_val;
        if (cl) mQ[commit_rd] = 0;
      end
    end
    mcnt = 0;
    for (int i = 0; i < 32; i++)
      if (mQ[i] != 0) mcnt++;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk_in) begin
    if (chk_on) begin
      bit a, d, c, cl;
      ctl(a, d, c, cl);
      if (dispatch_en && dispatch_tag == 0) begin
        fails++;
        $display("FAIL illegal_tag0: got 0 expected nonzero");
      end
      for (int k = 0; k < 2; k++) begin
        int r;
        logic [31:0] ev;
        logic [4:0]  et;
        r = int'(rs_idx[k*5 +: 5]);
        if (r == 0) begin
          ev = 0;
          et = 0;
        end else begin
          ev = (c && commit_rd == r) ? commit_val : mV[r];
          if (cl && commit_rd == r)      et = 0;
          else if (d && dispatch_rd == r) et = dispatch_tag;
          else if (rollback && a)         et = 0;
          else                            et = mQ[r];
        end
        chk($sformatf("m_val%0d_x%0d", k, r),
            64'(rs_val[k*32 +: 32]), 64'(ev));
        chk($sformatf("m_tag%0d_x%0d", k, r),
            64'(rs_tag[k*5 +: 5]), 64'(et));
      end
      chk("m_cnt", 64'(pending_cnt), 64'(mcnt));
      chk("m_allrdy", 64'(all_ready), 64'(mcnt == 0));
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic look;
    @(negedge clk_in);
  endtask

  task automatic idle;
    dispatch_en  = 0;
    dispatch_rd  = 0;
    dispatch_tag = 1;
    commit_en    = 0;
    commit_rd    = 0;
    commit_tag   = 0;
    commit_val   = 0;
    rollback     = 0;
  endtask

  task automatic disp(input logic [4:0] rd, input logic [4:0] tg);
    dispatch_en  = 1;
    dispatch_rd  = rd;
    dispatch_tag = tg;
  endtask

  task automatic comm(input logic [4:0] rd, input logic [4:0] tg,
                      input logic [31:0] v);
    commit_en  = 1;
    commit_rd  = rd;
    commit_tag = tg;
    commit_val = v;
  endtask

  task automatic rd2(input logic [4:0] a, input logic [4:0] b);
    rs_idx = {b, a};
  endtask

  initial begin
    rst_in = 1;
    rdy_in = 1;
    idle();
    rd2(5, 0);
    tick();
    tick();
    rst_in = 0;
    chk_on = 1;
    look();
    chk("rst_val0", 64'(rs_val[31:0]), 0);
    chk("rst_tag1", 64'(rs_tag[9:5]), 0);
    chk("rst_cnt", 64'(pending_cnt), 0);
    chk("rst_allrdy", 64'(all_ready), 1);

    tick(); disp(3, 7); rd2(3, 0);
    look(); chk("byp_tag7", 64'(rs_tag[4:0]), 7);
    tick(); idle();
    look(); chk("reg_tag7", 64'(rs_tag[4:0]), 7);
    chk("cnt1", 64'(pending_cnt), 1);
    chk("allrdy0", 64'(all_ready), 0);

    tick(); comm(3, 7, 32'hDEADBEEF); rd2(0, 3);
    look(); chk("cmt_byp_val", 64'(rs_val[63:32]), 64'hDEADBEEF);
    chk("cmt_byp_tag", 64'(rs_tag[9:5]), 0);
    tick(); idle();
    look(); chk("cmt_tag0", 64'(rs_tag[9:5]), 0);
    chk("cmt_cnt0", 64'(pending_cnt), 0);

    tick(); disp(4, 2); rd2(4, 4);
    tick(); disp(4, 9);
    tick(); idle(); comm(4, 2, 32'h11);
    tick(); idle();
    look(); chk("x4_val", 64'(rs_val[31:0]), 64'h11);
    chk("x4_tag9", 64'(rs_tag[4:0]), 9);
    chk("x4_cnt1", 64'(pending_cnt), 1);

    tick(); disp(6, 4); comm(6, 4, 32'h55); rd2(6, 4);
    tick(); idle();
    look(); chk("x6_tag0", 64'(rs_tag[4:0]), 0);
    chk("x6_val", 64'(rs_val[31:0]), 64'h55);
    tick(); disp(6, 5); comm(6, 4, 32'h55);
    tick(); idle();
    look(); chk("x6_tag5", 64'(rs_tag[4:0]), 5);
    chk("x6_cnt2", 64'(pending_cnt), 2);

    tick(); rollback = 1;
    tick(); idle();
    look(); chk("rb1_cnt0", 64'(pending_cnt), 0);
    tick(); disp(1, 1);
    tick(); disp(2, 2);
    tick(); disp(3, 3);
    tick(); idle(); rd2(8, 1);
    look(); chk("cnt3", 64'(pending_cnt), 3);
    tick(); rdy_in = 0; rollback = 1; disp(8, 3);
    look(); chk("frz_tag1", 64'(rs_tag[9:5]), 1);
    tick(); rdy_in = 1;
    look(); chk("frz_cnt3", 64'(pending_cnt), 3);
    chk("rb_byp_x1", 64'(rs_tag[9:5]), 0);
    chk("rb_byp_x8", 64'(rs_tag[4:0]), 0);
    tick(); idle();
    look(); chk("rb_x8_tag", 64'(rs_tag[4:0]), 0);
    chk("rb_x1_tag", 64'(rs_tag[9:5]), 0);
    chk("rb_cnt0", 64'(pending_cnt), 0);
    chk("rb_allrdy", 64'(all_ready), 1);

    tick(); disp(0, 3); comm(0, 0, 32'hFFFF); rd2(0, 0);
    look(); chk("x0_val", 64'(rs_val[31:0]), 0);
    tick(); idle(); rst_in = 1; disp(5, 6); comm(9, 0, 32'h77);
    tick(); idle(); rst_in = 0; rd2(5, 9);
    look(); chk("rstmid_tag", 64'(rs_tag[4:0]), 0);
    chk("rstmid_val", 64'(rs_val[63:32]), 0);

    for (int n = 0; n < 400; n++) begin
      tick();
      idle();
      rst_in      = ($urandom_range(0, 63) == 0);
      rdy_in      = ($urandom_range(0, 7) != 0);
      rollback    = ($urandom_range(0, 15) == 0);
      dispatch_en = $urandom_range(0, 1) == 1;
      dispatch_rd = 5'($urandom);
      dispatch_tag = 5'($urandom_range(1, 31));
      commit_en   = $urandom_range(0, 1) == 1;
      commit_rd   = ($urandom_range(0, 3) == 0) ? dispatch_rd
                                                : 5'($urandom);
      commit_tag  = $urandom_range(0, 1) == 1 ? mQ[commit_rd]
                                              : 5'($urandom);
      commit_val  = $urandom;
      rs_idx      = ($urandom_range(0, 3) == 0)
                    ? {commit_rd, dispatch_rd} : 10'($urandom);
    end
    tick();
    idle();
    rst_in = 0;
    rdy_in = 1;
    look();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
